// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser plus counter-qualified debounce for one
// raw pushbutton pin. The clean level feeds the key PIO in_port; optional
// single-cycle press/release strobes serve hardware consumers.
// Build option: define KEY_DEBOUNCE_PULSE_EN to generate press_pulse and
// release_pulse; when undefined both ports are tied to 0.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter logic        PRESSED_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam logic                 RELEASED_LEVEL = ~PRESSED_LEVEL;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST       = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Reject configurations whose counter cannot reach DEBOUNCE_CYCLES-1
    generate
        if ((DEBOUNCE_CYCLES < 2) ||
            (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH))) begin : g_bad_cfg
            $error("key_debouncer: DEBOUNCE_CYCLES must be in 2..2**CNT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    logic                 sync1_q, sync2_q;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 key_q, key_d;
    logic                 busy_q, busy_d;
    logic                 commit;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RELEASED_LEVEL;
            sync2_q <= RELEASED_LEVEL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered level/busy outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            key_q   <= RELEASED_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: qualify a departure from the committed level for DEBOUNCE_CYCLES
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync2_q != key_q) begin
                    state_d = ST_CHANGING;
                    cnt_d   = '0;
                end
            end
            ST_CHANGING: begin
                if (sync2_q == key_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        key_d  = commit ? sync2_q : key_q;
        busy_d = (state_d == ST_CHANGING);
    end

    assign key_out = key_q;
    assign busy    = busy_q;

`ifdef KEY_DEBOUNCE_PULSE_EN
    logic press_q, release_q;
    logic press_d, release_d;

    // Strobe direction follows the level being committed
    always_comb begin
        press_d   = commit && (sync2_q == PRESSED_LEVEL);
        release_d = commit && (sync2_q != PRESSED_LEVEL);
    end

    // Strobes registered so they coincide with the first cycle of the new key_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`else
    assign press_pulse   = 1'b0;
    assign release_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, PRESSED_LEVEL=0.
// Expected pulse values collapse to 0 when KEY_DEBOUNCE_PULSE_EN is undefined.
module tb_key_debouncer;

`ifdef KEY_DEBOUNCE_PULSE_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    logic clk, reset, key_in;
    logic key_out, press_pulse, release_pulse, busy;

    int checks   = 0;
    int failures = 0;

    key_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3),
        .PRESSED_LEVEL  (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .key_out      (key_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic eko, input logic eb,
                              input logic ep, input logic er);
        check({tag, ".key_out"}, key_out, eko);
        check({tag, ".busy"}, busy, eb);
        check({tag, ".press"}, press_pulse, ep & PE);
        check({tag, ".release"}, release_pulse, er & PE);
    endtask

    // One sampled edge with key_in=k, outputs checked 1 ns after it
    task automatic cyc(input logic k, input logic eko, input logic eb,
                       input logic ep, input logic er, input string tag);
        key_in = k;
        @(posedge clk);
        #1;
        check_outs(tag, eko, eb, ep, er);
    endtask

    // Press from released: edges m..m+7 with key_in held low
    task automatic press_seq(input string tag);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s.m0", tag));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s.m1", tag));
        for (int i = 2; i <= 5; i++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $sformatf("%s.m%0d", tag, i));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("%s.m6", tag));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("%s.m7", tag));
    endtask

    // Release from pressed: edges m..m+7 with key_in held high
    task automatic release_seq(input string tag);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("%s.m0", tag));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("%s.m1", tag));
        for (int i = 2; i <= 5; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s.m%0d", tag, i));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("%s.m6", tag));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s.m7", tag));
    endtask

    // Bounce train: 1/2/3-cycle low/high bursts then low held
    localparam logic BT_K  [20] = '{0,1,0,0,1,1,0,0,0,1,1,1,0,0,0,0,0,0,0,0};
    localparam logic BT_B  [20] = '{0,0,1,0,1,1,0,0,1,1,1,0,0,0,1,1,1,1,0,0};
    localparam logic BT_KO [20] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
    localparam logic BT_P  [20] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};

    // Glitch: low for 3 samples then high
    localparam logic GL_K [7] = '{0,0,0,1,1,1,1};
    localparam logic GL_B [7] = '{0,0,1,1,1,0,0};

    initial begin
        reset  = 1'b1;
        key_in = 1'b0;
        #1;
        check_outs("rst.t0", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rst.hold%0d", i));
        reset  = 1'b0;
        key_in = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("idle%0d", i));

        press_seq("press");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "press.hold");

        release_seq("rel");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rel.hold");

        for (int i = 0; i < 7; i++)
            cyc(GL_K[i], 1'b1, GL_B[i], 1'b0, 1'b0, $sformatf("glitch%0d", i));

        for (int i = 0; i < 20; i++)
            cyc(BT_K[i], BT_KO[i], BT_B[i], BT_P[i], 1'b0, $sformatf("bounce%0d", i));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bounce.hold");

        release_seq("rel2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rel2.hold");

        // Enter CHANGING, then reset asynchronously mid-qualification
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rmq.m0");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rmq.m1");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rmq.m2");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rmq.m3");
        #2;
        reset = 1'b1;
        #1;
        check_outs("rmq.async", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rmq.hold0");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rmq.hold1");
        reset = 1'b0;
        press_seq("rmq.post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
